// File: rtl/conv_8_32.sv
// Byte-to-word packer: big-endian 32-bit words into an FWFT word FIFO.
// Optional tkeep output and storage: define CONV_8_32_TKEEP_EN.
module conv_8_32 #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic [7:0]  data_in,
  input  logic        data_in_valid,
  input  logic        data_in_last,
  output logic [31:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  output logic        m_axis_tlast,
`ifdef CONV_8_32_TKEEP_EN
  output logic [3:0]  m_axis_tkeep,
`endif
  input  logic        m_axis_tready,
  output logic        udp_data_rx_done,
  output logic        overflow
);

  localparam int PW = $clog2(FIFO_DEPTH);
`ifdef CONV_8_32_TKEEP_EN
  localparam int EW = 37;
`else
  localparam int EW = 33;
`endif
  localparam logic [PW:0] FULL_CNT = (PW+1)'(FIFO_DEPTH);

  logic [1:0]    idx_q, idx_d;
  logic [23:0]   hold_q, hold_d;
  logic [31:0]   word_c;
  logic          complete;
  logic [EW-1:0] wr_entry;
  logic [EW-1:0] rd_entry;
`ifdef CONV_8_32_TKEEP_EN
  logic [3:0]    keep_c;
`endif

  always_comb begin
    word_c = {hold_q, 8'h00};
    unique case (idx_q)
      2'd0:    word_c[31:24] = data_in;
      2'd1:    word_c[23:16] = data_in;
      2'd2:    word_c[15:8]  = data_in;
      default: word_c[7:0]   = data_in;
    endcase
  end

`ifdef CONV_8_32_TKEEP_EN
  always_comb begin
    unique case (idx_q)
      2'd0:    keep_c = 4'b1000;
      2'd1:    keep_c = 4'b1100;
      2'd2:    keep_c = 4'b1110;
      default: keep_c = 4'b1111;
    endcase
  end
  assign wr_entry = {word_c, data_in_last, keep_c};
`else
  assign wr_entry = {word_c, data_in_last};
`endif

  assign complete = data_in_valid &&
                    (data_in_last || idx_q == 2'd3);

  always_comb begin
    idx_d  = idx_q;
    hold_d = hold_q;
    if (data_in_valid) begin
      if (complete) begin
        idx_d  = 2'd0;
        hold_d = 24'h0;
      end else begin
        idx_d  = idx_q + 2'd1;
        hold_d = word_c[31:8];
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      idx_q  <= 2'd0;
      hold_q <= 24'h0;
    end else begin
      idx_q  <= idx_d;
      hold_q <= hold_d;
    end
  end

  logic [EW-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic          empty, full, push, pop, drop;
  logic          done_q, ovf_q;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == FULL_CNT);
  assign pop   = !empty && m_axis_tready;
  // Full FIFO still accepts a word when a pop frees a slot this edge
  assign push  = complete && (!full || pop);
  assign drop  = complete && full && !pop;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push) wr_d = wr_q + 1'b1;
    if (pop)  rd_d = rd_q + 1'b1;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (push) mem_q[wr_q] <= wr_entry;
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
      done_q <= pop && m_axis_tlast;
      if (drop) ovf_q <= 1'b1;
    end
  end

  assign rd_entry = mem_q[rd_q];

  // Payload is gated so stale storage never shows while empty
  assign m_axis_tvalid = !empty;
  assign m_axis_tdata  = empty ? 32'h0 : rd_entry[EW-1 -: 32];
  assign m_axis_tlast  = !empty && rd_entry[EW-33];
`ifdef CONV_8_32_TKEEP_EN
  assign m_axis_tkeep  = empty ? 4'h0 : rd_entry[3:0];
`endif
  assign udp_data_rx_done = done_q;
  assign overflow         = ovf_q;

endmodule

// File: tb/tb_conv_8_32.sv
// Directed self-checking bench for conv_8_32.
// Checks tkeep only when CONV_8_32_TKEEP_EN is defined.
module tb_conv_8_32;

  logic        clk;
  logic        areset;
  logic [7:0]  data_in;
  logic        data_in_valid;
  logic        data_in_last;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tlast;
`ifdef CONV_8_32_TKEEP_EN
  logic [3:0]  m_axis_tkeep;
`endif
  logic        m_axis_tready;
  logic        udp_data_rx_done;
  logic        overflow;

  int n_chk;
  int n_fail;
  int cyc;

  logic [31:0] q_data [$];
  logic        q_last [$];
  logic [3:0]  q_keep [$];
  int          q_cyc  [$];
  int          d_cyc  [$];

  conv_8_32 #(.FIFO_DEPTH(4)) dut (
    .aclk             (clk),
    .areset           (areset),
    .data_in          (data_in),
    .data_in_valid    (data_in_valid),
    .data_in_last     (data_in_last),
    .m_axis_tdata     (m_axis_tdata),
    .m_axis_tvalid    (m_axis_tvalid),
    .m_axis_tlast     (m_axis_tlast),
`ifdef CONV_8_32_TKEEP_EN
    .m_axis_tkeep     (m_axis_tkeep),
`endif
    .m_axis_tready    (m_axis_tready),
    .udp_data_rx_done (udp_data_rx_done),
    .overflow         (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Record handshakes and done pulses between edges
  always @(negedge clk) begin
    if (!areset && m_axis_tvalid && m_axis_tready) begin
      q_data.push_back(m_axis_tdata);
      q_last.push_back(m_axis_tlast);
`ifdef CONV_8_32_TKEEP_EN
      q_keep.push_back(m_axis_tkeep);
`else
      q_keep.push_back(4'h0);
`endif
      q_cyc.push_back(cyc);
    end
    if (udp_data_rx_done) d_cyc.push_back(cyc);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic l);
    data_in       = b;
    data_in_valid = 1'b1;
    data_in_last  = l;
    tick();
  endtask

  task automatic idle();
    data_in       = 8'h00;
    data_in_valid = 1'b0;
    data_in_last  = 1'b0;
  endtask

  task automatic clear_q();
    q_data.delete();
    q_last.delete();
    q_keep.delete();
    q_cyc.delete();
    d_cyc.delete();
  endtask

  task automatic test_reset();
    areset = 1'b1;
    idle();
    m_axis_tready = 1'b1;
    tick();
    tick();
    n_chk++;
    if ({m_axis_tvalid, m_axis_tlast, m_axis_tdata} !== 34'h0) begin
      n_fail++;
      $display("FAIL rst_out: got v=%b l=%b d=%h want 0",
               m_axis_tvalid, m_axis_tlast, m_axis_tdata);
    end
    n_chk++;
    if ({udp_data_rx_done, overflow} !== 2'b00) begin
      n_fail++;
      $display("FAIL rst_flags: got done=%b ovf=%b want 00",
               udp_data_rx_done, overflow);
    end
`ifdef CONV_8_32_TKEEP_EN
    n_chk++;
    if (m_axis_tkeep !== 4'h0) begin
      n_fail++;
      $display("FAIL rst_keep: got %b want 0000", m_axis_tkeep);
    end
`endif
    areset = 1'b0;
    tick();
  endtask

  task automatic test_full_word();
    m_axis_tready = 1'b1;
    clear_q();
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    send(8'h33, 1'b0);
    send(8'h44, 1'b0);
    n_chk++;
    if ({m_axis_tvalid, m_axis_tdata} !== {1'b1, 32'h11223344}) begin
      n_fail++;
      $display("FAIL fw_latency: got v=%b d=%h want v=1 d=11223344",
               m_axis_tvalid, m_axis_tdata);
    end
    send(8'h55, 1'b0);
    send(8'h66, 1'b0);
    send(8'h77, 1'b0);
    send(8'h88, 1'b1);
    idle();
    repeat (4) tick();
    n_chk++;
    if (q_data.size() !== 2) begin
      n_fail++;
      $display("FAIL fw_count: got %0d want 2", q_data.size());
    end else begin
      n_chk++;
      if ({q_data[0], q_last[0]} !== {32'h11223344, 1'b0}) begin
        n_fail++;
        $display("FAIL fw_w0: got %h/%b want 11223344/0",
                 q_data[0], q_last[0]);
      end
      n_chk++;
      if ({q_data[1], q_last[1]} !== {32'h55667788, 1'b1}) begin
        n_fail++;
        $display("FAIL fw_w1: got %h/%b want 55667788/1",
                 q_data[1], q_last[1]);
      end
`ifdef CONV_8_32_TKEEP_EN
      n_chk++;
      if (q_keep[1] !== 4'b1111) begin
        n_fail++;
        $display("FAIL fw_keep: got %b want 1111", q_keep[1]);
      end
`endif
      n_chk++;
      if (d_cyc.size() !== 1) begin
        n_fail++;
        $display("FAIL fw_done_cnt: got %0d want 1", d_cyc.size());
      end else begin
        n_chk++;
        if (d_cyc[0] !== q_cyc[1] + 1) begin
          n_fail++;
          $display("FAIL fw_done_time: got %0d want %0d",
                   d_cyc[0], q_cyc[1] + 1);
        end
      end
    end
  endtask

  task automatic test_partial();
    logic [31:0] exp_w;
    logic [3:0]  exp_k;
    m_axis_tready = 1'b1;
    for (int n = 1; n <= 3; n++) begin
      exp_w = (n == 1) ? 32'h02000000 :
              (n == 2) ? 32'h02030000 : 32'h02030400;
      exp_k = (n == 1) ? 4'b1000 :
              (n == 2) ? 4'b1100 : 4'b1110;
      clear_q();
      send(8'hAA, 1'b0);
      send(8'hBB, 1'b0);
      send(8'hCC, 1'b0);
      send(8'h01, 1'b0);
      for (int i = 0; i < n; i++)
        send(8'(8'h02 + i), (i == n - 1));
      idle();
      repeat (4) tick();
      n_chk++;
      if (q_data.size() !== 2) begin
        n_fail++;
        $display("FAIL pt%0d_count: got %0d want 2", n, q_data.size());
      end else begin
        n_chk++;
        if ({q_data[0], q_last[0]} !== {32'hAABBCC01, 1'b0}) begin
          n_fail++;
          $display("FAIL pt%0d_w0: got %h/%b want AABBCC01/0",
                   n, q_data[0], q_last[0]);
        end
        n_chk++;
        if ({q_data[1], q_last[1]} !== {exp_w, 1'b1}) begin
          n_fail++;
          $display("FAIL pt%0d_tail: got %h/%b want %h/1",
                   n, q_data[1], q_last[1], exp_w);
        end
`ifdef CONV_8_32_TKEEP_EN
        n_chk++;
        if (q_keep[1] !== exp_k) begin
          n_fail++;
          $display("FAIL pt%0d_keep: got %b want %b", n, q_keep[1], exp_k);
        end
`endif
      end
      n_chk++;
      if (d_cyc.size() !== 1) begin
        n_fail++;
        $display("FAIL pt%0d_done: got %0d want 1", n, d_cyc.size());
      end
    end
  endtask

  task automatic test_back_to_back();
    m_axis_tready = 1'b1;
    clear_q();
    send(8'h5A, 1'b1);
    send(8'hA5, 1'b1);
    idle();
    repeat (4) tick();
    n_chk++;
    if (q_data.size() !== 2) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d want 2", q_data.size());
    end else begin
      n_chk++;
      if ({q_data[0], q_last[0], q_data[1], q_last[1]} !==
          {32'h5A000000, 1'b1, 32'hA5000000, 1'b1}) begin
        n_fail++;
        $display("FAIL b2b_words: got %h/%b %h/%b want 5A000000/1 A5000000/1",
                 q_data[0], q_last[0], q_data[1], q_last[1]);
      end
    end
    n_chk++;
    if (d_cyc.size() !== 2) begin
      n_fail++;
      $display("FAIL b2b_done: got %0d want 2", d_cyc.size());
    end
  endtask

  task automatic test_simul_pop();
    logic [31:0] exp_w;
    m_axis_tready = 1'b0;
    clear_q();
    for (int i = 0; i < 16; i++) send(8'(8'h30 + i), 1'b0);
    n_chk++;
    if ({m_axis_tvalid, m_axis_tdata} !== {1'b1, 32'h30313233}) begin
      n_fail++;
      $display("FAIL sp_full_head: got v=%b d=%h want v=1 d=30313233",
               m_axis_tvalid, m_axis_tdata);
    end
    send(8'h40, 1'b0);
    send(8'h41, 1'b0);
    send(8'h42, 1'b0);
    m_axis_tready = 1'b1;
    send(8'h43, 1'b1);
    idle();
    repeat (8) tick();
    n_chk++;
    if (overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL sp_ovf: got %b want 0", overflow);
    end
    n_chk++;
    if (q_data.size() !== 5) begin
      n_fail++;
      $display("FAIL sp_count: got %0d want 5", q_data.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        exp_w = {8'(8'h30 + 4*i), 8'(8'h31 + 4*i),
                 8'(8'h32 + 4*i), 8'(8'h33 + 4*i)};
        n_chk++;
        if ({q_data[i], q_last[i]} !== {exp_w, (i == 4)}) begin
          n_fail++;
          $display("FAIL sp_w%0d: got %h/%b want %h/%b",
                   i, q_data[i], q_last[i], exp_w, (i == 4));
        end
      end
    end
    n_chk++;
    if (d_cyc.size() !== 1) begin
      n_fail++;
      $display("FAIL sp_done: got %0d want 1", d_cyc.size());
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_w;
    m_axis_tready = 1'b0;
    clear_q();
    for (int i = 0; i < 20; i++) send(8'(8'h10 + i), (i == 19));
    n_chk++;
    if ({overflow, m_axis_tvalid, m_axis_tdata} !==
        {1'b1, 1'b1, 32'h10111213}) begin
      n_fail++;
      $display("FAIL bp_drop: got ovf=%b v=%b d=%h want 1 1 10111213",
               overflow, m_axis_tvalid, m_axis_tdata);
    end
    idle();
    repeat (3) tick();
    n_chk++;
    if ({overflow, m_axis_tdata, m_axis_tlast} !==
        {1'b1, 32'h10111213, 1'b0}) begin
      n_fail++;
      $display("FAIL bp_hold: got ovf=%b d=%h l=%b want 1 10111213 0",
               overflow, m_axis_tdata, m_axis_tlast);
    end
    m_axis_tready = 1'b1;
    repeat (8) tick();
    n_chk++;
    if (q_data.size() !== 4) begin
      n_fail++;
      $display("FAIL bp_count: got %0d want 4", q_data.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        exp_w = {8'(8'h10 + 4*i), 8'(8'h11 + 4*i),
                 8'(8'h12 + 4*i), 8'(8'h13 + 4*i)};
        n_chk++;
        if ({q_data[i], q_last[i]} !== {exp_w, 1'b0}) begin
          n_fail++;
          $display("FAIL bp_w%0d: got %h/%b want %h/0",
                   i, q_data[i], q_last[i], exp_w);
        end
      end
    end
    n_chk++;
    if ({d_cyc.size() == 0, overflow, m_axis_tvalid} !== 3'b110) begin
      n_fail++;
      $display("FAIL bp_after: got done=%0d ovf=%b v=%b want 0 1 0",
               d_cyc.size(), overflow, m_axis_tvalid);
    end
  endtask

  task automatic test_reset_midframe();
    m_axis_tready = 1'b0;
    clear_q();
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    send(8'h33, 1'b0);
    send(8'h44, 1'b0);
    send(8'hDE, 1'b0);
    send(8'hAD, 1'b0);
    idle();
    areset = 1'b1;
    tick();
    n_chk++;
    if ({m_axis_tvalid, m_axis_tlast, m_axis_tdata,
         udp_data_rx_done, overflow} !== 36'h0) begin
      n_fail++;
      $display("FAIL mr_rst: got v=%b l=%b d=%h done=%b ovf=%b want 0",
               m_axis_tvalid, m_axis_tlast, m_axis_tdata,
               udp_data_rx_done, overflow);
    end
    areset = 1'b0;
    m_axis_tready = 1'b1;
    send(8'h01, 1'b0);
    send(8'h02, 1'b0);
    send(8'h03, 1'b0);
    send(8'h04, 1'b1);
    idle();
    repeat (4) tick();
    n_chk++;
    if (q_data.size() !== 1) begin
      n_fail++;
      $display("FAIL mr_count: got %0d want 1", q_data.size());
    end else begin
      n_chk++;
      if ({q_data[0], q_last[0]} !== {32'h01020304, 1'b1}) begin
        n_fail++;
        $display("FAIL mr_word: got %h/%b want 01020304/1",
                 q_data[0], q_last[0]);
      end
    end
    n_chk++;
    if ({d_cyc.size() == 1, overflow} !== 2'b10) begin
      n_fail++;
      $display("FAIL mr_flags: got done=%0d ovf=%b want 1 0",
               d_cyc.size(), overflow);
    end
  endtask

  initial begin
    n_chk         = 0;
    n_fail        = 0;
    cyc           = 0;
    areset        = 1'b1;
    data_in       = 8'h00;
    data_in_valid = 1'b0;
    data_in_last  = 1'b0;
    m_axis_tready = 1'b0;
    test_reset();
    test_full_word();
    test_partial();
    test_back_to_back();
    test_simul_pop();
    test_backpressure();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
